uart_cmd_link: RTL and testbench

//  Host serial link that sits directly upstream of cmd_cfg. It contains a UART receiver and transmitter (8N1, LSB first).

---
 rtl/uart_cmd_link.sv | 183 ++++++++++++++++++
 tb/tb_uart_cmd_link.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_link.sv
// Host serial link: 8N1 UART receiver that pairs bytes into 16-bit commands,
// plus a transmitter that returns 8-bit response bytes to the host.
module uart_cmd_link #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam logic [11:0] FULL_CNT = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_CNT = 12'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SHIFT} tx_state_t;

  logic        rx_meta, rx_sync, rx_prev;
  rx_state_t   rx_state;
  logic [11:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        byte_done, frame_err, start_ok;
  logic        ptr_low;
  logic [7:0]  hold;

  tx_state_t   tx_state;
  logic [11:0] tx_cnt;
  logic [3:0]  tx_bits;
  logic [9:0]  tx_shift;

  // RX idles high, so the synchronizer resets to 1 to avoid a false start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      start_ok  <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      start_ok  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_CNT) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              start_ok <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 12'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == FULL_CNT) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 12'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == FULL_CNT) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) byte_done <= 1'b1;
            else         frame_err <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 12'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // A completed low byte sets cmd_rdy even if a clear arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd     <= '0;
      cmd_rdy <= 1'b0;
      ptr_low <= 1'b0;
      hold    <= '0;
    end else begin
      if (byte_done) begin
        if (ptr_low) begin
          cmd     <= {hold, rx_shift};
          ptr_low <= 1'b0;
        end else begin
          hold    <= rx_shift;
          ptr_low <= 1'b1;
        end
      end else if (frame_err) begin
        ptr_low <= 1'b0;
      end
      if (byte_done && ptr_low)
        cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || (start_ok && !ptr_low))
        cmd_rdy <= 1'b0;
    end
  end

  // The start bit goes on the wire at the accept edge; LOAD is its first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      TX        <= 1'b1;
      tx_cnt    <= '0;
      tx_bits   <= '0;
      tx_shift  <= '1;
      resp_sent <= 1'b0;
    end else begin
      resp_sent <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          TX <= 1'b1;
          if (send_resp) begin
            tx_shift <= {1'b1, resp, 1'b0};
            TX       <= 1'b0;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_state <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          tx_shift <= {1'b1, tx_shift[9:1]};
          tx_cnt   <= 12'd1;
          tx_state <= TX_SHIFT;
        end
        TX_SHIFT: begin
          if (tx_cnt == FULL_CNT) begin
            tx_cnt <= '0;
            if (tx_bits == 4'd9) begin
              resp_sent <= 1'b1;
              tx_state  <= TX_IDLE;
            end else begin
              TX       <= tx_shift[0];
              tx_shift <= {1'b1, tx_shift[9:1]};
              tx_bits  <= tx_bits + 4'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + 12'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_link.sv
// Directed bench for uart_cmd_link at BAUD_DIV=16: host model drives RX bit by
// bit and samples TX at mid-bit against hand-computed frames.
module tb_uart_cmd_link;

  localparam int BAUD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic        tx;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  int num_checks = 0;
  int num_fails  = 0;

  uart_cmd_link #(.BAUD_DIV(BAUD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (rx),
    .TX          (tx),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge, so drives never race the DUT.
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One host byte on RX: start, 8 data LSB first, given stop level, one idle bit.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    waitCycles(BAUD);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      waitCycles(BAUD);
    end
    rx = stop_bit;
    waitCycles(BAUD);
    rx = 1'b1;
    waitCycles(BAUD);
  endtask

  // Sends one response and checks every TX bit at mid-bit plus the resp_sent pulse.
  task automatic applyRespStimulus(input logic [7:0] b, input logic inject_busy);
    logic [9:0] frame;
    int pulses;
    frame  = {1'b1, b, 1'b0};
    pulses = 0;
    resp      = b;
    send_resp = 1'b1;
    waitCycles(1);
    send_resp = 1'b0;
    for (int c = 1; c <= 161; c++) begin
      waitCycles(1);
      if (resp_sent) pulses++;
      if ((c % BAUD) == BAUD / 2 && c < 10 * BAUD)
        checkOutput($sformatf("tx_bit%0d", c / BAUD), 32'(tx), 32'(frame[c / BAUD]));
      if (inject_busy && c == 72) begin
        resp      = 8'h00;
        send_resp = 1'b1;
      end
      if (inject_busy && c == 73) send_resp = 1'b0;
      if (c == 160) checkOutput("resp_sent_pulse", 32'(resp_sent), 32'd1);
      if (c == 161) checkOutput("resp_sent_drop", 32'(resp_sent), 32'd0);
    end
    checkOutput("resp_sent_count", 32'(pulses), 32'd1);
  endtask

  task automatic clearCmd();
    clr_cmd_rdy = 1'b1;
    waitCycles(1);
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    rx          = 1'b1;
    clr_cmd_rdy = 1'b0;
    resp        = 8'h00;
    send_resp   = 1'b0;
    waitCycles(3);
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_cmd", 32'(cmd), 32'h0);
    checkOutput("reset_cmd_rdy", 32'(cmd_rdy), 32'd0);
    checkOutput("reset_resp_sent", 32'(resp_sent), 32'd0);
    rst_n = 1'b1;
    waitCycles(5);

    // 1: two bytes form a command; cmd_rdy holds until cleared
    applyStimulus(8'h4B, 1'b1);
    checkOutput("t1_rdy_after_high", 32'(cmd_rdy), 32'd0);
    applyStimulus(8'hAF, 1'b1);
    checkOutput("t1_cmd", 32'(cmd), 32'h4BAF);
    checkOutput("t1_rdy", 32'(cmd_rdy), 32'd1);
    waitCycles(20);
    checkOutput("t1_rdy_held", 32'(cmd_rdy), 32'd1);
    clearCmd();
    checkOutput("t1_rdy_cleared", 32'(cmd_rdy), 32'd0);
    checkOutput("t1_cmd_kept", 32'(cmd), 32'h4BAF);

    // 2: response 0xA5 on TX
    applyRespStimulus(8'hA5, 1'b0);

    // 3: framing error drops the byte and re-aligns the pair
    applyStimulus(8'h12, 1'b0);
    checkOutput("t3_rdy_after_bad", 32'(cmd_rdy), 32'd0);
    applyStimulus(8'h4B, 1'b1);
    checkOutput("t3_rdy_after_high", 32'(cmd_rdy), 32'd0);
    applyStimulus(8'hAF, 1'b1);
    checkOutput("t3_cmd", 32'(cmd), 32'h4BAF);
    checkOutput("t3_rdy", 32'(cmd_rdy), 32'd1);
    clearCmd();

    // 4: short low glitch is rejected
    rx = 1'b0;
    waitCycles(4);
    rx = 1'b1;
    waitCycles(200);
    checkOutput("t4_rdy_after_glitch", 32'(cmd_rdy), 32'd0);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h01, 1'b1);
    checkOutput("t4_cmd", 32'(cmd), 32'h0001);
    checkOutput("t4_rdy", 32'(cmd_rdy), 32'd1);
    clearCmd();

    // 5: full duplex, with a second send_resp while busy
    fork
      begin
        applyStimulus(8'h80, 1'b1);
        applyStimulus(8'h00, 1'b1);
      end
      applyRespStimulus(8'hFF, 1'b1);
    join
    checkOutput("t5_cmd", 32'(cmd), 32'h8000);
    checkOutput("t5_rdy", 32'(cmd_rdy), 32'd1);
    waitCycles(200);
    checkOutput("t5_tx_idle", 32'(tx), 32'd1);

    // 6: a new high byte clears the stale cmd_rdy; then reset mid-frame
    applyStimulus(8'h77, 1'b1);
    checkOutput("t6_rdy_new_cmd", 32'(cmd_rdy), 32'd0);
    rx        = 1'b0;
    resp      = 8'h05;
    send_resp = 1'b1;
    waitCycles(1);
    send_resp = 1'b0;
    waitCycles(69);
    checkOutput("t6_tx_bit4", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_tx_async", 32'(tx), 32'd1);
    checkOutput("t6_rdy_reset", 32'(cmd_rdy), 32'd0);
    checkOutput("t6_cmd_reset", 32'(cmd), 32'h0);
    rx = 1'b1;
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(20);
    applyStimulus(8'h0B, 1'b1);
    applyStimulus(8'h55, 1'b1);
    checkOutput("t6_cmd", 32'(cmd), 32'h0B55);
    checkOutput("t6_rdy", 32'(cmd_rdy), 32'd1);
    checkOutput("t6_tx_idle", 32'(tx), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
